// File: rtl/uart_loader_if.sv
// Instruction-RAM write port and loader status, driven by uart_loader.
// master: the loader side (drives everything); slave: RAM / cpu side.
interface uart_loader_if #(
    parameter int ADDR_W = 10
);
    logic              imemWE;
    logic [ADDR_W-1:0] imemAddr;
    logic [31:0]       imemData;
    logic              cpuRst;
    logic              loadDone;
    logic              loadErr;

    modport master (output imemWE, imemAddr, imemData, cpuRst, loadDone, loadErr);
    modport slave  (input  imemWE, imemAddr, imemData, cpuRst, loadDone, loadErr);
endinterface

// File: rtl/uart_loader.sv
// Boot-time UART (8N1) image loader. Frame: A5, LEN_LO, LEN_HI, LEN words of
// 4 bytes (little endian), optional checksum byte. Words are written to the
// instruction RAM; the cpu is held in reset until the whole image is in.
// Optional feature: define LOADER_CHECKSUM_EN to require and check a trailing
// byte equal to the mod-256 sum of all payload bytes.
module uart_loader #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200,
    parameter int ADDR_W   = 10
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           uartRxPin,
    uart_loader_if.master  bus
);
    localparam int          DIV       = CLK_FREQ / BAUD;
    localparam int          CW        = $clog2(DIV);
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_next;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          half_tick, full_tick;
    logic          rx_valid, rx_ferr;
    logic [7:0]    rx_byte;

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    // Edge (not level) detect keeps a line stuck low after a framing
    // error from being read as a stream of start bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uartRxPin;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign half_tick = (rx_cnt == CW'(DIV / 2 - 1));
    assign full_tick = (rx_cnt == CW'(DIV - 1));

    // RX state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // RX next state: start re-checked at half bit, then one sample per bit
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (full_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX bit timer and LSB-first shift register; timer restarts on every
    // state change so data samples land DIV cycles apart from start centre
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_state != rx_next || full_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            else if (rx_state == RX_DATA && full_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // RX outputs: stop-bit sample decides good byte vs framing error
    always_comb begin
        rx_valid = (rx_state == RX_STOP) && full_tick &&  rx_sync;
        rx_ferr  = (rx_state == RX_STOP) && full_tick && !rx_sync;
        rx_byte  = rx_shift;
    end

    // ------------------------------------------------------------------
    // Frame FSM and write datapath
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_SYNC, ST_LEN0, ST_LEN1, ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE, ST_ERR
    } st_t;

    st_t               st, st_next;
    logic [15:0]       len;
    logic [15:0]       len_new;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_idx;
    logic [31:0]       word;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    assign len_new   = {rx_byte, len[7:0]};
    // word_idx has already been bumped when the strobe is out
    assign last_word = (32'(word_idx) == 32'(len));

    // Frame state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) st <= ST_SYNC;
        else     st <= st_next;
    end

    // Frame next state: bytes drive everything except the exit from DATA,
    // which waits for the final write strobe so the cpu is released only
    // after the last word is in RAM
    always_comb begin
        st_next = st;
        if (rx_ferr) begin
            if (st != ST_DONE) st_next = ST_ERR;
        end else if (rx_valid) begin
            unique case (st)
                ST_SYNC, ST_ERR: if (rx_byte == 8'hA5) st_next = ST_LEN0;
                ST_LEN0:         st_next = ST_LEN1;
                ST_LEN1: begin
                    if (len_new == 16'd0 || 32'(len_new) > MAX_WORDS)
                        st_next = ST_ERR;
                    else
                        st_next = ST_DATA;
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM:         st_next = (rx_byte == sum) ? ST_DONE : ST_ERR;
`endif
                default:         st_next = st;
            endcase
        end else if (st == ST_DATA && imem_we && last_word) begin
`ifdef LOADER_CHECKSUM_EN
            st_next = ST_CSUM;
`else
            st_next = ST_DONE;
`endif
        end
    end

    // Frame outputs: pure function of state, so DONE/ERR show the cycle after entry
    always_comb begin
        bus.cpuRst   = (st != ST_DONE);
        bus.loadDone = (st == ST_DONE);
        bus.loadErr  = (st == ST_ERR);
    end

    // Length capture, word assembly and the one-cycle RAM write strobe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len       <= '0;
            byte_idx  <= '0;
            word_idx  <= '0;
            word      <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (rx_valid) begin
                unique case (st)
                    ST_SYNC, ST_ERR: begin
                        if (rx_byte == 8'hA5) begin
                            byte_idx <= '0;
                            word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                            sum      <= '0;
`endif
                        end
                    end
                    ST_LEN0: len[7:0]  <= rx_byte;
                    ST_LEN1: len[15:8] <= rx_byte;
                    ST_DATA: begin
                        word     <= {rx_byte, word[31:8]};
                        byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum + rx_byte;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_data <= {rx_byte, word[31:8]};
                            imem_addr <= word_idx[ADDR_W-1:0];
                            word_idx  <= word_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.imemWE   = imem_we;
    assign bus.imemAddr = imem_addr;
    assign bus.imemData = imem_data;

endmodule
